// File: rtl/aes_block_loader.sv
// Packs a stream of WORD_W-bit words into DATA_W-bit key / plaintext blocks for a pipelined AES core.
// Define AES_LOADER_BYTESWAP_EN to byte-reverse every accepted word before packing; timing is unchanged.
module aes_block_loader #(
  parameter int DATA_W  = 128,
  parameter int WORD_W  = 32,
  parameter int KEY_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] s_word,
  input  logic              s_valid,
  input  logic              s_is_key,
  output logic              s_ready,
  output logic              cipherkey_valid_out,
  output logic [DATA_W-1:0] cipher_key,
  output logic              data_valid_out,
  output logic [DATA_W-1:0] plain_text,
  output logic              key_loaded,
  output logic              drop_err
);

  localparam int WORDS = DATA_W / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int STG_W = DATA_W - WORD_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [3:0] GAP_LOAD = (KEY_GAP > 0) ? 4'(KEY_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    COLLECT,
    KEY_PULSE,
    GAP,
    DATA_PULSE,
    DROP
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  word_cnt;
  logic [STG_W-1:0]  staging;
  logic              is_key_q;
  logic [3:0]        gap_cnt;
  logic [WORD_W-1:0] word_in;
  logic [DATA_W-1:0] block;
  logic              xfer;
  logic              last_xfer;
  logic              block_is_key;
  logic              ready_d;
  logic              key_pulse_d;
  logic              data_pulse_d;
  logic              drop_d;

`ifdef AES_LOADER_BYTESWAP_EN
  always_comb begin
    word_in = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_in[WORD_W - 8 * (b + 1) +: 8] = s_word[8 * b +: 8];
    end
  end
`else
  assign word_in = s_word;
`endif

  // Staging only keeps the earlier words; the final word joins straight from the bus.
  assign xfer         = s_valid && (state == COLLECT);
  assign last_xfer    = xfer && (word_cnt == LAST_WORD);
  assign block        = {staging, word_in};
  assign block_is_key = (word_cnt == '0) ? s_is_key : is_key_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: begin
        if (last_xfer) begin
          if (block_is_key) begin
            state_next = KEY_PULSE;
          end else if (key_loaded) begin
            state_next = DATA_PULSE;
          end else begin
            state_next = DROP;
          end
        end
      end
      KEY_PULSE:  state_next = (KEY_GAP > 0) ? GAP : COLLECT;
      GAP:        state_next = (gap_cnt == 4'd0) ? COLLECT : GAP;
      DATA_PULSE: state_next = COLLECT;
      DROP:       state_next = COLLECT;
      default:    state_next = COLLECT;
    endcase
  end

  // Each output is the registered image of the state about to be entered.
  always_comb begin
    ready_d      = (state_next == COLLECT);
    key_pulse_d  = (state_next == KEY_PULSE);
    data_pulse_d = (state_next == DATA_PULSE);
    drop_d       = (state_next == DROP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready             <= 1'b1;
      cipherkey_valid_out <= 1'b0;
      data_valid_out      <= 1'b0;
      drop_err            <= 1'b0;
      key_loaded          <= 1'b0;
      cipher_key          <= '0;
      plain_text          <= '0;
    end else begin
      s_ready             <= ready_d;
      cipherkey_valid_out <= key_pulse_d;
      data_valid_out      <= data_pulse_d;
      drop_err            <= drop_d;
      key_loaded          <= key_loaded | key_pulse_d;
      if (key_pulse_d) begin
        cipher_key <= block;
      end
      if (data_pulse_d) begin
        plain_text <= block;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      staging  <= '0;
      is_key_q <= 1'b0;
      gap_cnt  <= 4'd0;
    end else begin
      if (xfer) begin
        word_cnt <= last_xfer ? '0 : word_cnt + 1'b1;
        staging  <= block[STG_W-1:0];
        if (word_cnt == '0) begin
          is_key_q <= s_is_key;
        end
      end
      if (state == KEY_PULSE) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule
